// File: rtl/pc_sequencer.sv
// Program-counter sequencer: held PC with stall, conditional/unconditional branch,
// jump-register and a circular return-address stack for call/return.
module pc_sequencer #(
    parameter int            AW        = 32,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic [2:0]    mode,
    input  logic          ps,
    input  logic          z,
    input  logic [AW-1:0] bra,
    input  logic [AW-1:0] raa,
    input  logic          clr_ovf,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus1,
    output logic [AW-1:0] next_pc,
    output logic          taken,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_ovf,
    output logic          ras_unf
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [2:0] M_SEQ  = 3'b000;
    localparam logic [2:0] M_COND = 3'b001;
    localparam logic [2:0] M_JR   = 3'b010;
    localparam logic [2:0] M_BR   = 3'b011;
    localparam logic [2:0] M_CALL = 3'b100;
    localparam logic [2:0] M_RET  = 3'b101;

    logic [AW-1:0] pc_q, pc_d;
    logic [PW-1:0] top_q, top_d, top_inc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [AW-1:0] ras_q [RAS_DEPTH];
    logic          push, pop, unf_evt;

    assign pc        = pc_q;
    assign pc_plus1  = pc_q + AW'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
    // Circular pointer: wraps naturally because RAS_DEPTH is a power of two.
    assign top_inc   = top_q + PW'(1);

    always_comb begin
        next_pc = pc_plus1;
        taken   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        unf_evt = 1'b0;
        case (mode)
            M_COND: begin
                if (ps ^ z) begin
                    next_pc = bra;
                    taken   = 1'b1;
                end
            end
            M_JR: begin
                next_pc = raa;
                taken   = 1'b1;
            end
            M_BR: begin
                next_pc = bra;
                taken   = 1'b1;
            end
            M_CALL: begin
                next_pc = bra;
                taken   = 1'b1;
                push    = 1'b1;
            end
            M_RET: begin
                taken = 1'b1;
                if (ras_empty) begin
                    next_pc = raa;
                    unf_evt = 1'b1;
                end else begin
                    next_pc = ras_q[top_q];
                    pop     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        top_d = top_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = 1'b0;
        if (!stall) begin
            pc_d  = next_pc;
            unf_d = unf_evt;
            if (clr_ovf) begin
                ovf_d = 1'b0;
            end
            if (push) begin
                top_d = top_inc;
                if (ras_full) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (pop) begin
                top_d = top_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack entries carry no reset; validity is tracked entirely by cnt_q.
    always_ff @(posedge clk) begin
        if (!stall && push) begin
            ras_q[top_inc] <= pc_plus1;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against a queue-based model.
module tb_pc_sequencer;
    localparam int            AW  = 32;
    localparam int            D   = 4;
    localparam logic [AW-1:0] RPC = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic          ps = 1'b0;
    logic          z = 1'b0;
    logic [AW-1:0] bra = '0;
    logic [AW-1:0] raa = '0;
    logic          clr_ovf = 1'b0;
    logic [AW-1:0] pc, pc_plus1, next_pc;
    logic          taken, ras_empty, ras_full, ras_ovf, ras_unf;

    pc_sequencer #(.AW(AW), .RAS_DEPTH(D), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .mode(mode), .ps(ps), .z(z),
        .bra(bra), .raa(raa), .clr_ovf(clr_ovf), .pc(pc), .pc_plus1(pc_plus1),
        .next_pc(next_pc), .taken(taken), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the stack is a queue, newest entry at the back.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic          m_ovf, m_unf;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic predict(input logic [2:0] md, input logic p, input logic zz,
                           input logic [AW-1:0] b, input logic [AW-1:0] r,
                           output logic [AW-1:0] nxt, output logic tk);
        logic [AW-1:0] seq;
        seq = m_pc + 1;
        nxt = seq;
        tk  = 1'b0;
        case (md)
            3'd1: if (p != zz) begin nxt = b; tk = 1'b1; end
            3'd2: begin nxt = r; tk = 1'b1; end
            3'd3, 3'd4: begin nxt = b; tk = 1'b1; end
            3'd5: begin nxt = (m_stk.size() > 0) ? m_stk[$] : r; tk = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc_plus1"}, pc_plus1, m_pc + 1);
        chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, m_stk.size() == 0});
        chk({tag, ".full"}, {31'd0, ras_full}, {31'd0, m_stk.size() == D});
        chk({tag, ".ovf"}, {31'd0, ras_ovf}, {31'd0, m_ovf});
        chk({tag, ".unf"}, {31'd0, ras_unf}, {31'd0, m_unf});
    endtask

    // Called at posedge+1; applies inputs, checks mid-cycle, advances one edge.
    task automatic step(input string tag, input logic [2:0] md, input logic p, input logic zz,
                        input logic [AW-1:0] b, input logic [AW-1:0] r,
                        input logic st, input logic cl);
        logic [AW-1:0] nxt;
        logic          tk;
        int            sz;
        logic          ovf_set;
        mode = md; ps = p; z = zz; bra = b; raa = r; stall = st; clr_ovf = cl;
        #2;
        predict(md, p, zz, b, r, nxt, tk);
        check_state(tag);
        chk({tag, ".next_pc"}, next_pc, nxt);
        chk({tag, ".taken"}, {31'd0, taken}, {31'd0, tk});
        @(posedge clk);
        if (!st) begin
            sz      = m_stk.size();
            ovf_set = (md == 3'd4) && (sz == D);
            if (md == 3'd4) begin
                m_stk.push_back(m_pc + 1);
                if (m_stk.size() > D) m_stk.delete(0);
            end else if (md == 3'd5 && sz > 0) begin
                m_stk.delete(m_stk.size() - 1);
            end
            m_unf = (md == 3'd5) && (sz == 0);
            if (cl) m_ovf = 1'b0;
            if (ovf_set) m_ovf = 1'b1;
            m_pc = nxt;
        end else begin
            m_unf = 1'b0;
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_state("reset");
        rst_n = 1'b1;

        // Sequential fetch from reset.
        for (int i = 0; i < 3; i++) step("seq", 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Conditional branch both polarities.
        step("jr10", 3'd2, 1'b0, 1'b0, 32'h0, 32'h10, 1'b0, 1'b0);
        step("cond_t", 3'd1, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
        step("cond_nt", 3'd1, 1'b1, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);

        // Call / return pair.
        step("jr20", 3'd2, 1'b0, 1'b0, 32'h0, 32'h20, 1'b0, 1'b0);
        step("call", 3'd4, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
        step("ret", 3'd5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Overflow, four returns, then underflow.
        step("jr0", 3'd2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++)
            step("call_ov", 3'd4, 1'b0, 1'b0, 32'(i * 16), 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("ret_ov", 3'd5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("ret_unf", 3'd5, 1'b0, 1'b0, 32'h0, 32'h999, 1'b0, 1'b0);
        step("after_unf", 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Stall during CALL (clr_ovf ignored while stalled), then release.
        for (int i = 0; i < 3; i++) step("stall", 3'd4, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1);
        step("unstall", 3'd4, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
        step("clr", 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step("post_clr", 3'd6, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("rsv7", 3'd7, 1'b1, 1'b0, 32'h55, 32'h66, 1'b0, 1'b0);

        // PC wrap.
        step("jr_max", 3'd2, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step("wrap", 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Async reset mid-stack and mid-stall, no clock edge.
        step("c1", 3'd4, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
        step("c2", 3'd4, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
        mode = 3'd4; stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        @(posedge clk);
        #1;
        check_state("rst_hold");
        rst_n = 1'b1;
        step("post_rst", 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] md;
            md = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) md = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd5;
            step("rnd", md, 1'($urandom), 1'($urandom), 32'($urandom), 32'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
